// File: rtl/mips_rf_pkg.sv
// Shared widths and types for the register-file write arbiter and its scoreboard.
package mips_rf_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } requester_t;

endpackage

// File: rtl/mips_rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on reserve,
// cleared on commit; register 0 never pends.
module mips_rf_scoreboard
   import mips_rf_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_valid,
   input  logic [REG_ADDR_W-1:0] set_reg,
   input  logic                  clr_valid,
   input  logic [REG_ADDR_W-1:0] clr_reg,
   input  logic [REG_ADDR_W-1:0] lookup_1,
   input  logic [REG_ADDR_W-1:0] lookup_2,
   output logic                  hit_1,
   output logic                  hit_2,
   output logic [NUM_REGS-1:0]   pending_mask
);

   logic [NUM_REGS-1:0] mask_nxt;

   // Clear first so a same-cycle reservation of the committing register survives.
   always_comb begin
      mask_nxt = pending_mask;
      if (clr_valid)
         mask_nxt[clr_reg] = 1'b0;
      if (set_valid && (set_reg != REG_ZERO))
         mask_nxt[set_reg] = 1'b1;
      mask_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         pending_mask <= '0;
      else
         pending_mask <= mask_nxt;
   end

   assign hit_1 = pending_mask[lookup_1];
   assign hit_2 = pending_mask[lookup_2];

endmodule

// File: rtl/mips_regfile_write_arbiter.sv
// Round-robin arbiter between ALU (A) and load (B) writeback into the single
// register-file write port, with a registered write stage and RAW scoreboard.
module mips_regfile_write_arbiter
   import mips_rf_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [REG_ADDR_W-1:0] a_reg,
   input  logic [DATA_W-1:0]     a_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [REG_ADDR_W-1:0] b_reg,
   input  logic [DATA_W-1:0]     b_data,
   input  logic                  reserve_valid,
   input  logic [REG_ADDR_W-1:0] reserve_reg,
   input  logic [REG_ADDR_W-1:0] read_reg_1,
   input  logic [REG_ADDR_W-1:0] read_reg_2,
   output logic                  hazard_1,
   output logic                  hazard_2,
   output logic [REG_ADDR_W-1:0] write_reg,
   output logic [DATA_W-1:0]     write_data,
   output logic                  signal_reg_write,
   output logic [NUM_REGS-1:0]   pending_mask
);

   requester_t last_grant;
   requester_t last_grant_nxt;

   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= REQ_B;
      else
         last_grant <= last_grant_nxt;
   end

   // A lone requester always wins; on a tie the one not granted last goes.
   always_comb begin
      a_ready        = 1'b0;
      b_ready        = 1'b0;
      last_grant_nxt = last_grant;
      if (!reset) begin
         if (a_valid && (!b_valid || (last_grant == REQ_B)))
            a_ready = 1'b1;
         else if (b_valid)
            b_ready = 1'b1;
      end
      if (a_ready)
         last_grant_nxt = REQ_A;
      else if (b_ready)
         last_grant_nxt = REQ_B;
   end

   // Write stage: one-cycle pulse per transfer; register 0 is accepted but not written.
   always_ff @(posedge clk) begin
      if (reset) begin
         signal_reg_write <= 1'b0;
         write_reg        <= '0;
         write_data       <= '0;
      end else if (a_ready) begin
         signal_reg_write <= (a_reg != REG_ZERO);
         write_reg        <= a_reg;
         write_data       <= a_data;
      end else if (b_ready) begin
         signal_reg_write <= (b_reg != REG_ZERO);
         write_reg        <= b_reg;
         write_data       <= b_data;
      end else begin
         signal_reg_write <= 1'b0;
      end
   end

   mips_rf_scoreboard u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .set_valid    (reserve_valid),
      .set_reg      (reserve_reg),
      .clr_valid    (signal_reg_write),
      .clr_reg      (write_reg),
      .lookup_1     (read_reg_1),
      .lookup_2     (read_reg_2),
      .hit_1        (hazard_1),
      .hit_2        (hazard_2),
      .pending_mask (pending_mask)
   );

endmodule

// File: tb/tb_mips_regfile_write_arbiter.sv
// Self-checking bench: table of per-cycle vectors plus a queue of expected
// write-stage results, followed by a hand-written reset-during-write sequence.
module tb_mips_regfile_write_arbiter;
   import mips_rf_pkg::*;

   logic                  clk;
   logic                  reset;
   logic                  a_valid;
   logic                  a_ready;
   logic [REG_ADDR_W-1:0] a_reg;
   logic [DATA_W-1:0]     a_data;
   logic                  b_valid;
   logic                  b_ready;
   logic [REG_ADDR_W-1:0] b_reg;
   logic [DATA_W-1:0]     b_data;
   logic                  reserve_valid;
   logic [REG_ADDR_W-1:0] reserve_reg;
   logic [REG_ADDR_W-1:0] read_reg_1;
   logic [REG_ADDR_W-1:0] read_reg_2;
   logic                  hazard_1;
   logic                  hazard_2;
   logic [REG_ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0]     write_data;
   logic                  signal_reg_write;
   logic [NUM_REGS-1:0]   pending_mask;

   mips_regfile_write_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .a_valid          (a_valid),
      .a_ready          (a_ready),
      .a_reg            (a_reg),
      .a_data           (a_data),
      .b_valid          (b_valid),
      .b_ready          (b_ready),
      .b_reg            (b_reg),
      .b_data           (b_data),
      .reserve_valid    (reserve_valid),
      .reserve_reg      (reserve_reg),
      .read_reg_1       (read_reg_1),
      .read_reg_2       (read_reg_2),
      .hazard_1         (hazard_1),
      .hazard_2         (hazard_2),
      .write_reg        (write_reg),
      .write_data       (write_data),
      .signal_reg_write (signal_reg_write),
      .pending_mask     (pending_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [4:0]  ar;
      logic [31:0] ad;
      logic        bv;
      logic [4:0]  br;
      logic [31:0] bd;
      logic        rv;
      logic [4:0]  rr;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        ea;
      logic        eb;
      logic        eh1;
      logic        eh2;
      logic [31:0] emask;   // pending_mask at start of this cycle
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  rg;
      logic [31:0] d;
   } wr_t;

   localparam int unsigned NVEC = 24;
   vec_t vecs [NVEC];
   wr_t  exp_q [$];
   int   n_vec = 0;
   int   n_err = 0;
   logic [4:0]  last_rg = '0;
   logic [31:0] last_d  = '0;

   function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                               logic bv, logic [4:0] br, logic [31:0] bd,
                               logic rv, logic [4:0] rr, logic [4:0] r1, logic [4:0] r2,
                               logic ea, logic eb, logic eh1, logic eh2, logic [31:0] emask);
      vec_t v;
      v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
      v.rv = rv; v.rr = rr; v.r1 = r1; v.r2 = r2;
      v.ea = ea; v.eb = eb; v.eh1 = eh1; v.eh2 = eh2; v.emask = emask;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_write(input string tag);
      wr_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: expected-write queue empty", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, " we"},   32'(signal_reg_write), 32'(e.we));
         chk({tag, " reg"},  32'(write_reg),        32'(e.rg));
         chk({tag, " data"}, write_data,            e.d);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd,
                        input logic rv, input logic [4:0] rr,
                        input logic [4:0] r1, input logic [4:0] r2);
      a_valid = av; a_reg = ar; a_data = ad;
      b_valid = bv; b_reg = br; b_data = bd;
      reserve_valid = rv; reserve_reg = rr;
      read_reg_1 = r1; read_reg_2 = r2;
   endtask

   initial begin
      // av ar  ad     bv br  bd     rv rr  r1 r2 | ea eb h1 h2 mask
      vecs[0]  = mk(0, 0,  0,      0, 0,  0,      0, 0,  0, 0,  0, 0, 0, 0, 32'h0);
      vecs[1]  = mk(1, 5,  32'h11, 0, 0,  0,      0, 0,  0, 0,  1, 0, 0, 0, 32'h0);
      vecs[2]  = mk(0, 0,  0,      0, 0,  0,      0, 0,  0, 0,  0, 0, 0, 0, 32'h0);
      vecs[3]  = mk(0, 0,  0,      1, 4,  32'hB0, 0, 0,  0, 0,  0, 1, 0, 0, 32'h0);
      vecs[4]  = mk(1, 3,  32'hA3, 1, 4,  32'hB4, 0, 0,  0, 0,  1, 0, 0, 0, 32'h0);
      vecs[5]  = mk(1, 3,  32'hA3, 1, 4,  32'hB4, 0, 0,  0, 0,  0, 1, 0, 0, 32'h0);
      vecs[6]  = mk(1, 3,  32'hA3, 1, 4,  32'hB4, 0, 0,  0, 0,  1, 0, 0, 0, 32'h0);
      vecs[7]  = mk(1, 3,  32'hA3, 1, 4,  32'hB4, 0, 0,  0, 0,  0, 1, 0, 0, 32'h0);
      vecs[8]  = mk(0, 0,  0,      0, 0,  0,      1, 7,  7, 0,  0, 0, 0, 0, 32'h0);
      vecs[9]  = mk(0, 0,  0,      1, 7,  32'h77, 0, 0,  7, 0,  0, 1, 1, 0, 32'h80);
      vecs[10] = mk(0, 0,  0,      0, 0,  0,      0, 0,  7, 0,  0, 0, 1, 0, 32'h80);
      vecs[11] = mk(0, 0,  0,      0, 0,  0,      0, 0,  7, 0,  0, 0, 0, 0, 32'h0);
      vecs[12] = mk(0, 0,  0,      0, 0,  0,      1, 0,  0, 0,  0, 0, 0, 0, 32'h0);
      vecs[13] = mk(1, 0,  32'h99, 0, 0,  0,      0, 0,  0, 0,  1, 0, 0, 0, 32'h0);
      vecs[14] = mk(0, 0,  0,      0, 0,  0,      0, 0,  0, 0,  0, 0, 0, 0, 32'h0);
      vecs[15] = mk(0, 0,  0,      0, 0,  0,      1, 9,  9, 0,  0, 0, 0, 0, 32'h0);
      vecs[16] = mk(1, 9,  32'h09, 0, 0,  0,      0, 0,  9, 0,  1, 0, 1, 0, 32'h200);
      vecs[17] = mk(0, 0,  0,      0, 0,  0,      1, 9,  9, 0,  0, 0, 1, 0, 32'h200);
      vecs[18] = mk(0, 0,  0,      0, 0,  0,      0, 0,  9, 0,  0, 0, 1, 0, 32'h200);
      vecs[19] = mk(0, 0,  0,      1, 9,  32'h90, 0, 0,  9, 0,  0, 1, 1, 0, 32'h200);
      vecs[20] = mk(0, 0,  0,      0, 0,  0,      0, 0,  9, 0,  0, 0, 1, 0, 32'h200);
      vecs[21] = mk(0, 0,  0,      0, 0,  0,      0, 0,  9, 0,  0, 0, 0, 0, 32'h0);
      vecs[22] = mk(1, 12, 32'hCC, 0, 0,  0,      0, 0,  0, 12, 1, 0, 0, 0, 32'h0);
      vecs[23] = mk(0, 0,  0,      0, 0,  0,      0, 0,  0, 12, 0, 0, 0, 0, 32'h0);

      // Reset with both requesters asserting: nothing may be accepted.
      reset = 1'b1;
      drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1, 5'd3, 5'd3, 5'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset a_ready", 32'(a_ready), 32'd0);
      chk("reset b_ready", 32'(b_ready), 32'd0);
      chk("reset we", 32'(signal_reg_write), 32'd0);
      chk("reset reg", 32'(write_reg), 32'd0);
      chk("reset data", write_data, 32'd0);
      chk("reset mask", pending_mask, 32'd0);
      chk("reset hazard_1", 32'(hazard_1), 32'd0);
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back('{we: 1'b0, rg: 5'd0, d: 32'd0});

      for (int i = 0; i < int'(NVEC); i++) begin
         wr_t e;
         @(posedge clk);
         #1;
         check_write($sformatf("v%0d write", i));
         chk($sformatf("v%0d mask", i), pending_mask, vecs[i].emask);
         drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd,
               vecs[i].rv, vecs[i].rr, vecs[i].r1, vecs[i].r2);
         #1;
         chk($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(vecs[i].ea));
         chk($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(vecs[i].eb));
         chk($sformatf("v%0d hazard_1", i), 32'(hazard_1), 32'(vecs[i].eh1));
         chk($sformatf("v%0d hazard_2", i), 32'(hazard_2), 32'(vecs[i].eh2));
         if (vecs[i].ea) begin
            last_rg = vecs[i].ar;
            last_d  = vecs[i].ad;
            e = '{we: (vecs[i].ar != 5'd0), rg: vecs[i].ar, d: vecs[i].ad};
         end else if (vecs[i].eb) begin
            last_rg = vecs[i].br;
            last_d  = vecs[i].bd;
            e = '{we: (vecs[i].br != 5'd0), rg: vecs[i].br, d: vecs[i].bd};
         end else begin
            e = '{we: 1'b0, rg: last_rg, d: last_d};
         end
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      check_write("tail write");
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Transfer r6 while reserving r10, then reset during the write cycle.
      @(posedge clk);
      #1;
      drive(1, 5'd6, 32'h66, 0, 0, 0, 1, 5'd10, 5'd10, 5'd6);
      #1;
      chk("rst-seq a_ready", 32'(a_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("rst-seq inflight we", 32'(signal_reg_write), 32'd1);
      chk("rst-seq mask set", pending_mask, 32'h400);
      reset = 1'b1;
      drive(1, 5'd1, 32'h101, 1, 5'd2, 32'h202, 0, 0, 5'd10, 5'd6);
      #1;
      chk("rst-seq a_ready in reset", 32'(a_ready), 32'd0);
      chk("rst-seq b_ready in reset", 32'(b_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rst-seq we after reset", 32'(signal_reg_write), 32'd0);
      chk("rst-seq reg after reset", 32'(write_reg), 32'd0);
      chk("rst-seq mask after reset", pending_mask, 32'd0);
      chk("rst-seq hazard_1 after reset", 32'(hazard_1), 32'd0);
      reset = 1'b0;
      #1;
      chk("rst-seq tie a_ready", 32'(a_ready), 32'd1);
      chk("rst-seq tie b_ready", 32'(b_ready), 32'd0);
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst-seq tie we", 32'(signal_reg_write), 32'd1);
      chk("rst-seq tie reg", 32'(write_reg), 32'd1);
      chk("rst-seq tie data", write_data, 32'h101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mips_regfile_write_arbiter.md
Name: mips_regfile_write_arbiter

Overview:
Shares the single write port of mips_registers between two writeback requesters: A (ALU result) and B (memory load). It also keeps a 32-entry pending-write scoreboard so the decode stage can detect RAW hazards on its two read addresses. It sits between the execute/memory stages and the register file's write_reg, write_data and signal_reg_write inputs. Round-robin arbitration with a registered write stage.

Parameters:
REG_ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, number of architectural registers (2**REG_ADDR_W)

Ports:
clk  in  1  rising-edge clock, sole clock domain
reset  in  1  synchronous, active-high reset
a_valid  in  1  requester A has a write pending
a_ready  out  1  A transfer accepted this cycle (combinational)
a_reg  in  REG_ADDR_W  A destination register
a_data  in  DATA_W  A write data
b_valid  in  1  requester B has a write pending
b_ready  out  1  B transfer accepted this cycle (combinational)
b_reg  in  REG_ADDR_W  B destination register
b_data  in  DATA_W  B write data
reserve_valid  in  1  issue stage reserves a destination this cycle
reserve_reg  in  REG_ADDR_W  register being reserved
read_reg_1  in  REG_ADDR_W  decode read address 1
read_reg_2  in  REG_ADDR_W  decode read address 2
hazard_1  out  1  read_reg_1 has an uncommitted producer
hazard_2  out  1  read_reg_2 has an uncommitted producer
write_reg  out  REG_ADDR_W  to register file
write_data  out  DATA_W  to register file
signal_reg_write  out  1  register file write enable
pending_mask  out  NUM_REGS  scoreboard contents, for debug

Behaviour:
- Transfer: X_valid && X_ready at a clk edge.
- Readiness: ready never depends on the other requester's ready. The write stage drains every cycle, so there is no backpressure except arbitration.
- Arbitration:
  - Only one requester valid: it gets ready=1.
  - Both valid: the requester not granted last gets ready=1; the other gets 0.
  - Neither valid: both ready=0.
- Priority pointer last_grant: updated only on an accepted transfer. Reset value = B, so A wins the first tie.
- Write stage, cycle N+1 after a transfer in cycle N:
  - write_reg and write_data hold the granted values.
  - signal_reg_write=1 for exactly that cycle, unless the destination is register 0.
  - A register-0 transfer is accepted (ready asserted) but produces signal_reg_write=0.
- Idle cycle: signal_reg_write=0; write_reg and write_data hold their last values.
- Scoreboard, bit r:
  - Set at the edge where reserve_valid && reserve_reg==r && r!=0.
  - Cleared at the edge ending a cycle where signal_reg_write=1 && write_reg==r (the commit edge).
  - Simultaneous set and clear of the same r: set wins (newer producer).
  - Bit 0 is constantly 0.
- Hazards: hazard_k = pending_mask[read_reg_k] (combinational). Hazard stays high through the commit cycle and drops the cycle after, when the register file holds the new value. No bypass.
- A transfer to a register whose bit is not set is legal: written, scoreboard unchanged.
- Reset values: signal_reg_write=0, write_reg=0, write_data=0, pending_mask=0, last_grant=B.
- Reset mid-operation: the in-flight write is cancelled (signal_reg_write=0 in the cycle after reset) and all reservations are dropped. a_ready and b_ready are forced to 0 while reset is high.
- Total latency: 1 cycle from transfer to register-file write enable.

Decomposition:
- Package mips_rf_pkg:
  - REG_ADDR_W, DATA_W, NUM_REGS
  - REG_ZERO = 0
  - requester enum {REQ_A, REQ_B} used for last_grant
- Sub-module mips_rf_scoreboard: set port, clear port, two lookup ports, pending_mask output.
- Arbiter and write stage stay in the top module.

Test Plan:
- Reset, then a_valid=1 a_reg=5 a_data=0x11 for one cycle -> a_ready=1; next cycle signal_reg_write=1, write_reg=5, write_data=0x11; then 0.
- a_valid and b_valid held for 4 cycles (a_reg=3, b_reg=4) -> grants A,B,A,B; write_reg sequence 3,4,3,4 with no idle cycles.
- reserve_valid reserve_reg=7, then read_reg_1=7 -> hazard_1=1; B writes r7 -> hazard_1 stays 1 through the commit cycle, 0 the following cycle; pending_mask[7]=0.
- reserve_reg=0, then a_reg=0 transfer -> pending_mask stays 0, a_ready=1, signal_reg_write never 1, hazard on read_reg=0 always 0.
- Commit of r9 in the same cycle as a new reserve_reg=9 -> pending_mask[9]=1 afterwards, hazard persists.
- Transfer accepted, reset asserted the next cycle -> signal_reg_write=0, pending_mask=0, ready=0; after release, a tie is won by A.
